// File: rtl/picomips_pkg.sv
// Shared picoMIPS types and constants used by fetch, decode and instruction memory.
package picomips_pkg;

  localparam int unsigned PC_WIDTH    = 8;
  localparam int unsigned INSTR_WIDTH = 16;
  localparam logic [INSTR_WIDTH-1:0] HALT_INSTR = 16'hFFFF;

  typedef logic [PC_WIDTH-1:0]    pc_t;
  typedef logic [INSTR_WIDTH-1:0] instr_t;

  // What the fetch registers do on the coming edge.
  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_HALT,
    SEL_JUMP,
    SEL_BRANCH,
    SEL_SEQ
  } pc_sel_e;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC selection: halt > stall > jump > branch > halt-detect > sequential.
module pc_next
  import picomips_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] ir_pc,
  input  logic             ir_valid,
  input  logic             halted,
  input  logic             halt_hit,
  input  logic             stall,
  input  logic             jump_en,
  input  logic [WIDTH-1:0] jump_addr,
  input  logic             branch_en,
  input  logic [WIDTH-1:0] branch_offset,
  output logic [WIDTH-1:0] next_pc,
  output pc_sel_e          sel
);

  always_comb begin
    sel     = SEL_SEQ;
    next_pc = pc + WIDTH'(1);
    if (halted) begin
      sel     = SEL_HALT;
      next_pc = pc;
    end else if (stall) begin
      sel     = SEL_HOLD;
      next_pc = pc;
    end else if (ir_valid && jump_en) begin
      sel     = SEL_JUMP;
      next_pc = jump_addr;
    end else if (ir_valid && branch_en) begin
      // Relative to the branch's own address; wraps modulo 2^WIDTH.
      sel     = SEL_BRANCH;
      next_pc = ir_pc + branch_offset;
    end else if (halt_hit) begin
      sel     = SEL_HALT;
      next_pc = pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// picoMIPS fetch stage: PC, instruction register, halt detection and fetch counter.
module fetch_unit
  import picomips_pkg::*;
#(
  parameter int unsigned                PC_WIDTH    = 8,
  parameter int unsigned                INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]        RESET_PC    = 8'h00,
  parameter logic [INSTR_WIDTH-1:0]     HALT_INSTR  = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   branch_en,
  input  logic [PC_WIDTH-1:0]    branch_offset,
  input  logic                   jump_en,
  input  logic [PC_WIDTH-1:0]    jump_addr,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_instr,
  output logic [INSTR_WIDTH-1:0] ir,
  output logic [PC_WIDTH-1:0]    ir_pc,
  output logic                   ir_valid,
  output logic                   halted,
  output logic [15:0]            fetch_count
);

  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] next_pc;
  pc_sel_e             sel;
  logic                halt_hit;

  assign imem_addr = pc;
  assign halt_hit  = ir_valid && (ir == HALT_INSTR);

  pc_next #(
    .WIDTH (PC_WIDTH)
  ) u_pc_next (
    .pc            (pc),
    .ir_pc         (ir_pc),
    .ir_valid      (ir_valid),
    .halted        (halted),
    .halt_hit      (halt_hit),
    .stall         (stall),
    .jump_en       (jump_en),
    .jump_addr     (jump_addr),
    .branch_en     (branch_en),
    .branch_offset (branch_offset),
    .next_pc       (next_pc),
    .sel           (sel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      ir          <= '0;
      ir_pc       <= '0;
      ir_valid    <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      pc <= next_pc;
      case (sel)
        SEL_HALT: begin
          halted   <= 1'b1;
          ir_valid <= 1'b0;
        end
        SEL_JUMP, SEL_BRANCH: ir_valid <= 1'b0;
        SEL_SEQ: begin
          ir       <= imem_instr;
          ir_pc    <= pc;
          ir_valid <= 1'b1;
          if (fetch_count != '1) fetch_count <= fetch_count + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized run against a reference model.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_en;
  logic [7:0]  branch_offset;
  logic        jump_en;
  logic [7:0]  jump_addr;
  logic [7:0]  imem_addr;
  logic [15:0] imem_instr;
  logic [15:0] ir;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        halted;
  logic [15:0] fetch_count;

  logic [15:0] mem [256];
  int checks;
  int errors;

  // Reference model state
  logic [7:0]  m_pc;
  logic [15:0] m_ir;
  logic [7:0]  m_ir_pc;
  logic        m_valid;
  logic        m_halted;
  int          m_cnt;

  fetch_unit #(
    .PC_WIDTH    (8),
    .INSTR_WIDTH (16),
    .RESET_PC    (8'h00),
    .HALT_INSTR  (16'hFFFF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_en     (branch_en),
    .branch_offset (branch_offset),
    .jump_en       (jump_en),
    .jump_addr     (jump_addr),
    .imem_addr     (imem_addr),
    .imem_instr    (imem_instr),
    .ir            (ir),
    .ir_pc         (ir_pc),
    .ir_valid      (ir_valid),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  assign imem_instr = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step();
    if (reset) begin
      m_pc = 8'h00; m_ir = 16'h0; m_ir_pc = 8'h00;
      m_valid = 1'b0; m_halted = 1'b0; m_cnt = 0;
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (stall) begin
      // everything holds
    end else if (m_valid && jump_en) begin
      m_pc = jump_addr; m_valid = 1'b0;
    end else if (m_valid && branch_en) begin
      m_pc = 8'((int'(m_ir_pc) + int'($signed(branch_offset)) + 256) % 256);
      m_valid = 1'b0;
    end else if (m_valid && m_ir == 16'hFFFF) begin
      m_halted = 1'b1; m_valid = 1'b0;
    end else begin
      m_ir = mem[m_pc]; m_ir_pc = m_pc; m_valid = 1'b1;
      m_pc = 8'((int'(m_pc) + 1) % 256);
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; stall = 1'b0; branch_en = 1'b0; jump_en = 1'b0;
    branch_offset = 8'h00; jump_addr = 8'h00;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    checks++; if (ir !== 16'h0) begin errors++; $display("FAIL reset_ir got %h want 0000", ir); end
    checks++; if (ir_pc !== 8'h00) begin errors++; $display("FAIL reset_ir_pc got %h want 00", ir_pc); end
    checks++; if (ir_valid !== 1'b0) begin errors++; $display("FAIL reset_ir_valid got %b want 0", ir_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
    checks++; if (fetch_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", fetch_count); end
    checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_pc got %h want 00", imem_addr); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++; if (ir !== 16'(16'h1000 + i)) begin errors++; $display("FAIL seq_ir[%0d] got %h want %h", i, ir, 16'(16'h1000 + i)); end
      checks++; if (ir_pc !== 8'(i)) begin errors++; $display("FAIL seq_ir_pc[%0d] got %h want %h", i, ir_pc, 8'(i)); end
      checks++; if (ir_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got %b want 1", i, ir_valid); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      branch_en = (i == 1); jump_en = (i == 2); jump_addr = 8'h77; branch_offset = 8'h10;
      cycle();
      checks++; if (imem_addr !== 8'h03) begin errors++; $display("FAIL stall_pc[%0d] got %h want 03", i, imem_addr); end
      checks++; if (ir !== 16'h1002 || ir_pc !== 8'h02) begin errors++; $display("FAIL stall_ir[%0d] got %h@%h want 1002@02", i, ir, ir_pc); end
      checks++; if (fetch_count !== 16'd3 || ir_valid !== 1'b1) begin errors++; $display("FAIL stall_count[%0d] got %0d/%b want 3/1", i, fetch_count, ir_valid); end
    end
    idle_inputs();
    cycle();
    checks++; if (ir !== 16'h1003 || ir_pc !== 8'h03) begin errors++; $display("FAIL stall_release got %h@%h want 1003@03", ir, ir_pc); end
    checks++; if (fetch_count !== 16'd4) begin errors++; $display("FAIL seq_count got %0d want 4", fetch_count); end
  endtask

  task automatic test_branch();
    cycle();
    cycle();
    checks++; if (ir_pc !== 8'h05 || imem_addr !== 8'h06) begin errors++; $display("FAIL br_setup got ir_pc %h pc %h want 05/06", ir_pc, imem_addr); end
    branch_en = 1'b1; branch_offset = 8'hFD;
    cycle();
    idle_inputs();
    checks++; if (ir_valid !== 1'b0 || imem_addr !== 8'h02) begin errors++; $display("FAIL br_target got valid %b pc %h want 0/02", ir_valid, imem_addr); end
    cycle();
    checks++; if (ir !== 16'h1002 || ir_pc !== 8'h02 || ir_valid !== 1'b1) begin errors++; $display("FAIL br_fetch got %h@%h v%b want 1002@02 v1", ir, ir_pc, ir_valid); end
  endtask

  task automatic test_jump_priority();
    stall = 1'b1; jump_en = 1'b1; jump_addr = 8'h40; branch_en = 1'b1; branch_offset = 8'h20;
    cycle();
    checks++; if (imem_addr !== 8'h03 || ir_valid !== 1'b1) begin errors++; $display("FAIL jmp_stalled got pc %h v%b want 03 v1", imem_addr, ir_valid); end
    stall = 1'b0;
    cycle();
    checks++; if (imem_addr !== 8'h40 || ir_valid !== 1'b0) begin errors++; $display("FAIL jmp_wins got pc %h v%b want 40 v0", imem_addr, ir_valid); end
    // With ir_valid=0 the redirect must be ignored in favour of a sequential fetch.
    jump_addr = 8'h80; branch_en = 1'b0;
    cycle();
    idle_inputs();
    checks++; if (ir_pc !== 8'h40 || ir !== 16'h1040 || imem_addr !== 8'h41 || ir_valid !== 1'b1) begin
      errors++; $display("FAIL jmp_ignored got %h@%h pc %h v%b want 1040@40 pc 41 v1", ir, ir_pc, imem_addr, ir_valid);
    end
  endtask

  task automatic test_wrap();
    jump_en = 1'b1; jump_addr = 8'hFE;
    cycle();
    idle_inputs();
    cycle();
    checks++; if (ir_pc !== 8'hFE || imem_addr !== 8'hFF) begin errors++; $display("FAIL wrap_setup got ir_pc %h pc %h want FE/FF", ir_pc, imem_addr); end
    branch_en = 1'b1; branch_offset = 8'h05;
    cycle();
    idle_inputs();
    checks++; if (imem_addr !== 8'h03) begin errors++; $display("FAIL wrap_branch got pc %h want 03", imem_addr); end
    cycle();
    jump_en = 1'b1; jump_addr = 8'hFF;
    cycle();
    idle_inputs();
    cycle();
    checks++; if (ir_pc !== 8'hFF || imem_addr !== 8'h00 || ir !== 16'h10FF) begin errors++; $display("FAIL wrap_pc got %h@%h pc %h want 10FF@FF pc 00", ir, ir_pc, imem_addr); end
  endtask

  task automatic test_halt();
    mem[6] = 16'hFFFF;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) cycle();
    checks++; if (ir !== 16'hFFFF || ir_valid !== 1'b1 || halted !== 1'b0) begin errors++; $display("FAIL halt_word got %h v%b h%b want FFFF v1 h0", ir, ir_valid, halted); end
    cycle();
    checks++; if (halted !== 1'b1 || ir_valid !== 1'b0 || imem_addr !== 8'h07) begin errors++; $display("FAIL halt_enter got h%b v%b pc %h want h1 v0 pc 07", halted, ir_valid, imem_addr); end
    for (int i = 0; i < 10; i++) begin
      stall = 1'($urandom); jump_en = 1'($urandom); branch_en = 1'($urandom);
      jump_addr = 8'($urandom); branch_offset = 8'($urandom);
      cycle();
      checks++; if (imem_addr !== 8'h07 || halted !== 1'b1 || ir_valid !== 1'b0 || fetch_count !== 16'd7 || ir !== 16'hFFFF) begin
        errors++; $display("FAIL halt_hold[%0d] got pc %h h%b v%b cnt %0d ir %h want 07 h1 v0 7 FFFF", i, imem_addr, halted, ir_valid, fetch_count, ir);
      end
    end
    idle_inputs();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    checks++; if (halted !== 1'b0 || fetch_count !== 16'd0 || imem_addr !== 8'h00 || ir !== 16'h0) begin errors++; $display("FAIL halt_reset got h%b cnt %0d pc %h ir %h want 0 0 00 0000", halted, fetch_count, imem_addr, ir); end
    cycle();
    checks++; if (ir !== 16'h1000 || ir_pc !== 8'h00 || ir_valid !== 1'b1) begin errors++; $display("FAIL halt_restart got %h@%h v%b want 1000@00 v1", ir, ir_pc, ir_valid); end
    mem[6] = 16'h1006;
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 39) == 0) ? 16'hFFFF : 16'($urandom);
    for (int i = 0; i < 600; i++) begin
      reset         = ($urandom_range(0, 49) == 0);
      stall         = ($urandom_range(0, 4) == 0);
      jump_en       = ($urandom_range(0, 7) == 0);
      branch_en     = ($urandom_range(0, 5) == 0);
      jump_addr     = 8'($urandom);
      branch_offset = 8'($urandom);
      cycle();
      checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d] got %h want %h", i, imem_addr, m_pc); end
      checks++; if (ir !== m_ir || ir_pc !== m_ir_pc) begin errors++; $display("FAIL rnd_ir[%0d] got %h@%h want %h@%h", i, ir, ir_pc, m_ir, m_ir_pc); end
      checks++; if (ir_valid !== m_valid || halted !== m_halted) begin errors++; $display("FAIL rnd_flags[%0d] got v%b h%b want v%b h%b", i, ir_valid, halted, m_valid, m_halted); end
      checks++; if (fetch_count !== 16'(m_cnt)) begin errors++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, fetch_count, m_cnt); end
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(16'h1000 + i);
    idle_inputs();
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jump_priority();
    test_wrap();
    test_halt();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
